// File: rtl/sequencer_m_pkg.sv
// legv8_pkg: shared states and constants for the LEGv8 control sequencer
package legv8_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB
    } state_t;
    localparam logic [5:0] OP_BL = 6'b100101;
    localparam int CB_NZ_BIT = 24;
    localparam int PC_INC = 4;
endpackage

// File: rtl/sequencer_m_if.sv
// sequencer_m_if: fetch, data-memory, decoder and strobe signals of the sequencer
interface sequencer_m_if #(parameter int DATA_W = 32);
    logic              run;
    logic              imem_req;
    logic [DATA_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic              Uncondbranch;
    logic              Branch;
    logic              MemRead;
    logic              MemWrite;
    logic              RegWrite;
    logic [DATA_W-1:0] immediate;
    logic              zero;
    logic              dmem_req;
    logic              dmem_we;
    logic              dmem_ack;
    logic              reg_we;
    logic              link_we;
    logic [DATA_W-1:0] link_data;
    logic [DATA_W-1:0] pc;
    logic              retire;
    modport master (
        input  run, imem_ack, imem_rdata, Uncondbranch, Branch, MemRead, MemWrite,
               RegWrite, immediate, zero, dmem_ack,
        output imem_req, imem_addr, instr, dmem_req, dmem_we, reg_we, link_we,
               link_data, pc, retire
    );
    modport slave (
        output run, imem_ack, imem_rdata, Uncondbranch, Branch, MemRead, MemWrite,
               RegWrite, immediate, zero, dmem_ack,
        input  imem_req, imem_addr, instr, dmem_req, dmem_we, reg_we, link_we,
               link_data, pc, retire
    );
endinterface

// File: rtl/sequencer_m_next_pc.sv
// next_pc_m: sequential/branch target and return address from the current pc
module next_pc_m
    import legv8_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_immediate,
    input  logic              i_taken,
    output logic [DATA_W-1:0] o_next_pc,
    output logic [DATA_W-1:0] o_link_data
);
    assign o_link_data = i_pc + DATA_W'(PC_INC);
    assign o_next_pc   = i_taken ? i_pc + (i_immediate << 2) : o_link_data;
endmodule

// File: rtl/sequencer_m.sv
// sequencer_m: multi-cycle LEGv8 fetch/decode/execute/mem/write-back controller
module sequencer_m
    import legv8_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          reset,
    sequencer_m_if.master bus
);
    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_link_data;
    logic [31:0]       r_instr;
    logic [DATA_W-1:0] w_next_pc;
    logic [DATA_W-1:0] w_link_data;
    logic              w_is_bl;
    logic              w_taken;
    logic              w_retire;

    assign w_is_bl = r_instr[31:26] == OP_BL;
    assign w_taken = bus.Uncondbranch | (bus.Branch & (bus.zero ^ r_instr[CB_NZ_BIT]));

    next_pc_m #(.DATA_W(DATA_W)) u_next_pc (
        .i_pc        (r_pc),
        .i_immediate (bus.immediate),
        .i_taken     (w_taken),
        .o_next_pc   (w_next_pc),
        .o_link_data (w_link_data)
    );

    // next state and retire decision; retiring states return to FETCH or park in IDLE
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_IDLE:    w_next = bus.run ? S_FETCH : S_IDLE;
            S_FETCH:   w_next = bus.imem_ack ? S_DECODE : S_FETCH;
            S_DECODE:  w_next = S_EXECUTE;
            S_EXECUTE: begin
                if (bus.MemRead | bus.MemWrite) w_next = S_MEM;
                else if (bus.RegWrite | w_is_bl) w_next = S_WB;
                else w_retire = 1'b1;
            end
            S_MEM: begin
                if (bus.dmem_ack) begin
                    if (bus.MemRead) w_next = S_WB;
                    else w_retire = 1'b1;
                end
            end
            S_WB:      w_retire = 1'b1;
            default:   w_next = S_IDLE;
        endcase
        if (w_retire) w_next = bus.run ? S_FETCH : S_IDLE;
    end

    // state, pc, latched instruction and return address registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_link_data <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && bus.imem_ack) r_instr <= bus.imem_rdata;
            if (r_state == S_DECODE) r_link_data <= w_link_data;
            if (w_retire) r_pc <= w_next_pc;
        end
    end

    assign bus.imem_req  = r_state == S_FETCH;
    assign bus.imem_addr = r_pc;
    assign bus.instr     = r_instr;
    assign bus.dmem_req  = r_state == S_MEM;
    assign bus.dmem_we   = (r_state == S_MEM) & bus.MemWrite;
    assign bus.reg_we    = (r_state == S_WB) & bus.RegWrite;
    assign bus.link_we   = (r_state == S_WB) & w_is_bl;
    assign bus.link_data = r_link_data;
    assign bus.pc        = r_pc;
    assign bus.retire    = w_retire;
endmodule

// File: tb/tb_sequencer_m.sv
// tb_sequencer_m: directed instruction sequences with hand-computed expectations
module tb_sequencer_m;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc, nreg, reg_cyc, ndreq, ndwe, nlink;
    logic [31:0] link_val, ins_ret;
    logic done;

    sequencer_m_if #(.DATA_W(32)) bus ();

    sequencer_m #(.DATA_W(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input string name, input logic [31:0] ins, input logic u, input logic b,
                            input logic mr, input logic mw, input logic rw, input logic [31:0] imm,
                            input logic z, input int dwait, input int exp_cyc, input logic [31:0] exp_pc);
        int mcnt;
        bus.Uncondbranch = u;
        bus.Branch       = b;
        bus.MemRead      = mr;
        bus.MemWrite     = mw;
        bus.RegWrite     = rw;
        bus.immediate    = imm;
        bus.zero         = z;
        bus.imem_rdata   = ins;
        cyc = 0; nreg = 0; reg_cyc = 0; ndreq = 0; ndwe = 0; nlink = 0;
        link_val = '0; ins_ret = '0; done = 1'b0; mcnt = 0;
        while (!done && cyc < 20) begin
            cyc++;
            bus.imem_ack = bus.imem_req;
            if (bus.dmem_req) mcnt++;
            bus.dmem_ack = bus.dmem_req && mcnt > dwait;
            #1;
            if (bus.reg_we) begin nreg++; reg_cyc = cyc; end
            if (bus.dmem_req) ndreq++;
            if (bus.dmem_we) ndwe++;
            if (bus.link_we) begin nlink++; link_val = bus.link_data; end
            if (bus.retire) begin done = 1'b1; ins_ret = bus.instr; end
            step();
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        chk({name, "_retired"}, 32'(done), 32'd1);
        chk({name, "_cycles"}, cyc, exp_cyc);
        chk({name, "_pc"}, bus.pc, exp_pc);
        chk({name, "_instr"}, ins_ret, ins);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.run = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_ack = 1'b0;
        bus.Uncondbranch = 1'b0; bus.Branch = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
        bus.RegWrite = 1'b0; bus.immediate = '0; bus.zero = 1'b0;
        step();
        step();
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_link_data", bus.link_data, 32'h0);
        chk("rst_strobes", {26'd0, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.reg_we, bus.link_we, bus.retire}, 32'h0);
        reset = 1'b0;
        bus.run = 1'b1;
        step();
        chk("first_imem_req", 32'(bus.imem_req), 32'd1);
        chk("first_imem_addr", bus.imem_addr, 32'h0);

        do_instr("add0", 32'h8B010022, 0, 0, 0, 0, 1, 32'h0, 0, 0, 4, 32'h4);
        chk("add0_reg_we_count", nreg, 1);
        chk("add0_reg_we_cycle", reg_cyc, 4);
        chk("add0_no_dmem", ndreq, 0);
        do_instr("add4", 32'h8B010022, 0, 0, 0, 0, 1, 32'h0, 0, 0, 4, 32'h8);

        do_instr("b_m1", 32'h17FFFFFF, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 3, 32'h4);
        chk("b_m1_no_reg_we", nreg, 0);
        chk("b_m1_no_dmem", ndreq, 0);
        do_instr("b_p3", 32'h14000003, 1, 0, 0, 0, 0, 32'h3, 0, 0, 3, 32'h10);

        do_instr("cbz_z0", 32'hB40000E3, 0, 1, 0, 0, 0, 32'h7, 0, 0, 3, 32'h14);
        do_instr("b_back1", 32'h17FFFFFF, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 3, 32'h10);
        do_instr("cbz_z1", 32'hB40000E3, 0, 1, 0, 0, 0, 32'h7, 1, 0, 3, 32'h2C);
        do_instr("b_back7", 32'h17FFFFF9, 1, 0, 0, 0, 0, 32'hFFFF_FFF9, 0, 0, 3, 32'h10);
        do_instr("cbnz_z1", 32'hB50000E3, 0, 1, 0, 0, 0, 32'h7, 1, 0, 3, 32'h14);
        do_instr("b_back2", 32'h17FFFFFF, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 3, 32'h10);
        do_instr("cbnz_z0", 32'hB50000E3, 0, 1, 0, 0, 0, 32'h7, 0, 0, 3, 32'h2C);
        do_instr("b_back3", 32'h17FFFFFD, 1, 0, 0, 0, 0, 32'hFFFF_FFFD, 0, 0, 3, 32'h20);

        do_instr("bl", 32'h94000002, 1, 0, 0, 0, 0, 32'h2, 0, 0, 4, 32'h28);
        chk("bl_link_we_count", nlink, 1);
        chk("bl_link_data", link_val, 32'h24);
        chk("bl_no_reg_we", nreg, 0);

        do_instr("ldr", 32'hF8400281, 0, 0, 1, 0, 1, 32'h0, 0, 3, 8, 32'h2C);
        chk("ldr_dmem_req_cycles", ndreq, 4);
        chk("ldr_dmem_we", ndwe, 0);
        chk("ldr_reg_we_cycle", reg_cyc, 8);
        chk("ldr_reg_we_count", nreg, 1);

        do_instr("str", 32'hF81F4281, 0, 0, 0, 1, 0, 32'h0, 0, 0, 4, 32'h30);
        chk("str_dmem_we", ndwe, 1);
        chk("str_no_reg_we", nreg, 0);

        bus.MemRead = 1'b1; bus.MemWrite = 1'b0; bus.RegWrite = 1'b1;
        bus.Uncondbranch = 1'b0; bus.Branch = 1'b0;
        bus.imem_rdata = 32'hF8400281;
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        step();
        step();
        chk("rmem_in_mem", 32'(bus.dmem_req), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.dmem_ack = 1'b1;
        chk("rmem_pc", bus.pc, 32'h0);
        chk("rmem_instr", bus.instr, 32'h0);
        chk("rmem_idle", {30'd0, bus.imem_req, bus.dmem_req}, 32'h0);
        chk("rmem_no_reg_we", 32'(bus.reg_we), 32'd0);
        step();
        bus.dmem_ack = 1'b0;
        chk("rmem_fetch_after", 32'(bus.imem_req), 32'd1);
        chk("rmem_late_ack_reg_we", 32'(bus.reg_we), 32'd0);
        chk("rmem_late_ack_pc", bus.pc, 32'h0);

        bus.run = 1'b0;
        do_instr("add_park", 32'h8B010022, 0, 0, 0, 0, 1, 32'h0, 0, 0, 4, 32'h4);
        chk("park_idle", 32'(bus.imem_req), 32'd0);
        step();
        chk("park_hold", 32'(bus.imem_req), 32'd0);
        bus.run = 1'b1;
        step();
        chk("park_resume", 32'(bus.imem_req), 32'd1);
        chk("park_resume_addr", bus.imem_addr, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sequencer_m.md
# sequencer_m

Multi-cycle control sequencer for the LEGv8 datapath. Owns the program counter and fetches instructions over a request/acknowledge instruction-memory port. Presents each instruction to the decoder and register file, then steps through decode, execute, memory and write-back, gating register and memory strobes from the decoder's control outputs. Computes the next PC for sequential flow, B, BL, CBZ and CBNZ.

## Interface
Parameters:
- DATA_W, 32, width of PC, instruction, immediate and link data
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  level; sequencer fetches while high and parks in IDLE after the current instruction retires when low
- imem_req  out  1  instruction fetch request
- imem_addr  out  DATA_W  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- instr  out  32  latched instruction to decoder
- Uncondbranch, Branch, MemRead, MemWrite, RegWrite  in  1 each  decoder control outputs
- immediate  in  DATA_W  signed word offset from decoder
- zero  in  1  ALU result == 0
- dmem_req  out  1  data memory request
- dmem_we  out  1  store qualifier, valid while dmem_req is high
- dmem_ack  in  1  data access complete
- reg_we  out  1  one-cycle register-file write strobe
- link_we  out  1  one-cycle X30 write strobe for BL
- link_data  out  DATA_W  return address (pc+4)
- pc  out  DATA_W  current PC
- retire  out  1  one-cycle pulse when an instruction completes

## Operation
- States are IDLE, FETCH, DECODE, EXECUTE, MEM and WB.
- IDLE: if run is high, go to FETCH. Otherwise hold.
- FETCH: assert imem_req with imem_addr = pc. On imem_ack, latch imem_rdata into instr and go to DECODE. Hold the request and address stable until ack.
- DECODE: one settle cycle, then go to EXECUTE.
- EXECUTE:
  - If MemRead or MemWrite, go to MEM.
  - Else if RegWrite or is_bl (instr[31:26] = 6'b100101), go to WB.
  - Else update the PC and retire.
- MEM: assert dmem_req, with dmem_we = MemWrite. On dmem_ack:
  - If MemRead, go to WB.
  - Otherwise update the PC and retire.
- WB: reg_we = RegWrite; link_we = is_bl with link_data = pc+4. Update the PC and retire.
- Retire: pulse retire. Next state is FETCH if run is high, else IDLE.
- Branch decision: taken = Uncondbranch | (Branch & (zero ^ instr[24])). instr[24]=0 selects CBZ, 1 selects CBNZ.
- Next PC:
  - Taken: pc + (immediate << 2).
  - Not taken: pc + 4.
  - All arithmetic is DATA_W bits and wraps modulo 2^DATA_W. Bits shifted out above DATA_W are discarded.
- instr and pc are stable from DECODE through retire.

## Timing
- Reset values: state IDLE, pc=RESET_PC, instr=0, link_data=0. imem_req, dmem_req, dmem_we, reg_we, link_we and retire are all 0.
- Latency with zero-wait memories (ack in the first request cycle):
  - ALU/ADDI: 4 cycles (FETCH, DECODE, EXECUTE, WB).
  - B/CBZ/CBNZ: 3 cycles.
  - STR: 4 cycles.
  - LDR and BL: LDR 5 cycles, BL 4 cycles.
  - Each memory wait cycle adds 1.
- pc changes on the same edge that leaves the retiring state. retire is high in that final cycle.
- imem_ack or dmem_ack outside its waiting state is ignored.
- run falling mid-instruction does not abort the instruction; it only affects the post-retire transition.
- reset in any state, including an outstanding request, returns all registers to reset values on that edge. Requests drop the next cycle and any late ack is ignored.
- Simultaneous reset and ack: reset wins.

## Structure
- Package legv8_pkg holds:
  - the state enum;
  - OP_BL = 6'b100101;
  - CB_NZ_BIT = 24;
  - PC_INC = 4.
- Sub-module next_pc_m is purely combinational. It takes pc, immediate, taken and produces next_pc and link_data. It is shared with the future pipelined fetch unit.

## Test plan
- Reset, then run=1: pc=0 and all strobes 0 during reset. imem_req=1 with imem_addr=0 in the first cycle after IDLE.
- ADD X2,X1,X1 (32'h8B010022) at pc=0, zero-wait: reg_we high exactly once in cycle 4, retire in the same cycle, pc=4 afterwards.
- B #-1 (32'h17FFFFFF) at pc=8: no reg_we/dmem_req, pc=4 after 3 cycles.
- CBZ X3,#7 (32'hB40000E3) at pc=0x10: zero=1 gives pc=0x2C; zero=0 gives pc=0x14. Repeat with CBNZ (instr[24]=1) and expect the inverse outcomes.
- LDR X1,[X20,#0] (32'hF8400281) with dmem_ack delayed 3 cycles: dmem_req high for 4 cycles with dmem_we=0, reg_we one cycle after ack. STR (32'hF81F4281): dmem_we=1, no reg_we.
- BL #2 (32'h94000002) at pc=0x20: link_we=1 and link_data=0x24, then pc=0x28. Separately, assert reset during MEM with ack arriving the next cycle: pc=0, state IDLE, ack ignored, no reg_we.
